// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared definitions for the cardinal data-memory path.
//   ADDR_W / DATA_W : dmem word address and data widths (256 x 64)
//   LOCK_MAX        : default cap on consecutive locked cycles
//   mst_e           : master identifier (processor, NIC)
//   arb_st_e        : dmem port arbiter ownership state
package cardinal_pkg;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 64;
   localparam int LOCK_MAX = 16;

   typedef enum logic {
      MST_P = 1'b0,
      MST_N = 1'b1
   } mst_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_P = 2'd1,
      OWN_N = 2'd2
   } arb_st_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way chooser for the dmem port.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin conflict
// resolution in IDLE; otherwise the processor always wins a conflict.
//   p_req, n_req : requests from processor / NIC
//   last_grant   : master granted most recently
//   state        : current ownership state
//   gnt          : one-hot grant, bit 0 = processor, bit 1 = NIC
module dmem_arb_pick
   import cardinal_pkg::*;
(
   input  logic       p_req,
   input  logic       n_req,
   input  mst_e       last_grant,
   input  arb_st_e    state,
   output logic [1:0] gnt
);

   logic prefer_n;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   // Alternate on conflict: hand the port to whoever did not go last.
   assign prefer_n = (last_grant == MST_P);
`else
   // Fixed priority; last_grant is tracked by the top but not used here.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign prefer_n          = 1'b0;
`endif

   always_comb begin
      gnt = 2'b00;
      case (state)
         OWN_P:   gnt[0] = p_req;
         OWN_N:   gnt[1] = n_req;
         default: begin
            if (p_req && n_req) begin
               gnt[1] = prefer_n;
               gnt[0] = !prefer_n;
            end else begin
               gnt = {n_req, p_req};
            end
         end
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-ported 256 x 64 dmem between the
// processor load/store path (P_*) and the NIC DMA engine (N_*).
// Build option: DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_pick).
//   Clock, Reset                : rising-edge clock, async active-low reset
//   x_Req/Wr/Lock/Addr/WData    : master request, held until x_Gnt
//   x_Gnt                       : access issued to dmem this cycle
//   x_RData/x_RValid            : read data, valid one cycle after the grant
//   DmemEn/DmemWrEn/Mem_Addr/Data_Out/Data_In : dmem side
//   Busy                        : a master currently owns the port (lock)
module dmem_port_arbiter #(
   parameter int ADDR_W   = cardinal_pkg::ADDR_W,
   parameter int DATA_W   = cardinal_pkg::DATA_W,
   parameter int LOCK_MAX = cardinal_pkg::LOCK_MAX
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              P_Req,
   input  logic              P_Wr,
   input  logic              P_Lock,
   input  logic [ADDR_W-1:0] P_Addr,
   input  logic [DATA_W-1:0] P_WData,
   input  logic              N_Req,
   input  logic              N_Wr,
   input  logic              N_Lock,
   input  logic [ADDR_W-1:0] N_Addr,
   input  logic [DATA_W-1:0] N_WData,
   output logic              P_Gnt,
   output logic              N_Gnt,
   output logic [DATA_W-1:0] P_RData,
   output logic [DATA_W-1:0] N_RData,
   output logic              P_RValid,
   output logic              N_RValid,
   output logic              DmemEn,
   output logic              DmemWrEn,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Data_Out,
   input  logic [DATA_W-1:0] Data_In,
   output logic              Busy
);

   import cardinal_pkg::*;

   localparam int               CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   arb_st_e           state;
   logic [CNT_W-1:0]  lock_cnt;
   mst_e              last_grant;
   logic              rd_vld;     // a read was issued last cycle
   mst_e              rd_tag;     // which master that read belongs to
   logic [DATA_W-1:0] p_hold;
   logic [DATA_W-1:0] n_hold;
   logic [1:0]        pick_gnt;
   logic [1:0]        gnt;

   dmem_arb_pick u_pick (
      .p_req      (P_Req),
      .n_req      (N_Req),
      .last_grant (last_grant),
      .state      (state),
      .gnt        (pick_gnt)
   );

   // No access may reach the dmem while reset is held.
   assign gnt   = pick_gnt & {2{Reset}};
   assign P_Gnt = gnt[0];
   assign N_Gnt = gnt[1];

   assign DmemEn   = |gnt;
   assign DmemWrEn = gnt[1] ? N_Wr : (gnt[0] & P_Wr);
   assign Mem_Addr = gnt[1] ? N_Addr  : (gnt[0] ? P_Addr  : '0);
   assign Data_Out = gnt[1] ? N_WData : (gnt[0] ? P_WData : '0);

   assign Busy = (state != IDLE);

   // Data_In is live only in the cycle after a read grant; outside it
   // each master sees the last word it was delivered.
   assign P_RValid = rd_vld && (rd_tag == MST_P);
   assign N_RValid = rd_vld && (rd_tag == MST_N);
   assign P_RData  = P_RValid ? Data_In : p_hold;
   assign N_RData  = N_RValid ? Data_In : n_hold;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         lock_cnt   <= '0;
         last_grant <= MST_N;
         rd_vld     <= 1'b0;
         rd_tag     <= MST_P;
         p_hold     <= '0;
         n_hold     <= '0;
      end else begin
         rd_vld <= DmemEn && !DmemWrEn;
         rd_tag <= gnt[1] ? MST_N : MST_P;
         if (P_RValid) p_hold <= Data_In;
         if (N_RValid) n_hold <= Data_In;
         if (DmemEn)   last_grant <= gnt[1] ? MST_N : MST_P;

         case (state)
            IDLE: begin
               lock_cnt <= '0;
               if (gnt[0] && P_Lock)      state <= OWN_P;
               else if (gnt[1] && N_Lock) state <= OWN_N;
            end
            OWN_P: begin
               lock_cnt <= lock_cnt + 1'b1;
               if (lock_cnt == CNT_LAST || (gnt[0] && !P_Lock)) state <= IDLE;
            end
            OWN_N: begin
               lock_cnt <= lock_cnt + 1'b1;
               if (lock_cnt == CNT_LAST || (gnt[1] && !N_Lock)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios followed by random traffic.
// A reference model (owner / held-cycle count / last winner, plus a word
// array for memory contents) predicts grants each cycle and queues the
// expected read data; the monitor pops on every RValid.
module tb_dmem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 64;
   localparam int LM = 16;

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic          P_Req = 1'b0, P_Wr = 1'b0, P_Lock = 1'b0;
   logic [AW-1:0] P_Addr = '0;
   logic [DW-1:0] P_WData = '0;
   logic          N_Req = 1'b0, N_Wr = 1'b0, N_Lock = 1'b0;
   logic [AW-1:0] N_Addr = '0;
   logic [DW-1:0] N_WData = '0;
   logic          P_Gnt, N_Gnt, P_RValid, N_RValid;
   logic [DW-1:0] P_RData, N_RData;
   logic          DmemEn, DmemWrEn, Busy;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Data_Out;
   logic [DW-1:0] Data_In;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
      .Clock(Clock), .Reset(Reset),
      .P_Req(P_Req), .P_Wr(P_Wr), .P_Lock(P_Lock), .P_Addr(P_Addr), .P_WData(P_WData),
      .N_Req(N_Req), .N_Wr(N_Wr), .N_Lock(N_Lock), .N_Addr(N_Addr), .N_WData(N_WData),
      .P_Gnt(P_Gnt), .N_Gnt(N_Gnt), .P_RData(P_RData), .N_RData(N_RData),
      .P_RValid(P_RValid), .N_RValid(N_RValid),
      .DmemEn(DmemEn), .DmemWrEn(DmemWrEn), .Mem_Addr(Mem_Addr),
      .Data_Out(Data_Out), .Data_In(Data_In), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   // Physical dmem: synchronous write, one-cycle read.
   logic [DW-1:0] init_val [256];
   logic [DW-1:0] mem      [256];
   bit            mem_loaded;
   always @(posedge Clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val[i];
         mem_loaded <= 1'b1;
      end else if (DmemEn) begin
         if (DmemWrEn) mem[Mem_Addr] <= Data_Out;
         else          Data_In <= mem[Mem_Addr];
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
   endtask

   // Reference model state
   logic [DW-1:0] ref_mem [256];
   bit            ref_loaded;
   int            owner;      // 0 none, 1 processor, 2 NIC
   int            held;       // cycles spent owning so far
   int            last;       // 1 processor, 2 NIC
   bit            exp_rv_p, exp_rv_n;
   logic [DW-1:0] p_q[$], n_q[$];
   logic [DW-1:0] p_hold, n_hold;
   bit            eg_p, eg_n, wr;
   logic [AW-1:0] ad;
   logic [DW-1:0] wd;

   always @(negedge Clock) begin
      if (!ref_loaded) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = init_val[i];
         ref_loaded = 1'b1;
      end
      if (!Reset) begin
         chk("rst_gnt",    {P_Gnt, N_Gnt}, 0);
         chk("rst_rvalid", {P_RValid, N_RValid}, 0);
         chk("rst_dmem",   {DmemEn, DmemWrEn}, 0);
         chk("rst_busy",   Busy, 0);
         chk("rst_p_rdata", P_RData, 0);
         chk("rst_n_rdata", N_RData, 0);
         owner = 0; held = 0; last = 2;
         exp_rv_p = 0; exp_rv_n = 0;
         p_q.delete(); n_q.delete();
         p_hold = '0; n_hold = '0;
      end else begin
         // read return
         chk("p_rvalid", P_RValid, exp_rv_p);
         chk("n_rvalid", N_RValid, exp_rv_n);
         if (P_RValid || exp_rv_p) begin
            if (p_q.size() == 0) chk("p_rvalid_unexpected", P_RValid, 0);
            else p_hold = p_q.pop_front();
         end
         if (N_RValid || exp_rv_n) begin
            if (n_q.size() == 0) chk("n_rvalid_unexpected", N_RValid, 0);
            else n_hold = n_q.pop_front();
         end
         chk("p_rdata", P_RData, p_hold);
         chk("n_rdata", N_RData, n_hold);

         // expected grant
         eg_p = 0; eg_n = 0;
         if (owner == 1) eg_p = P_Req;
         else if (owner == 2) eg_n = N_Req;
         else if (P_Req && N_Req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (last == 1) eg_n = 1; else eg_p = 1;
`else
            eg_p = 1;
`endif
         end else begin
            eg_p = P_Req; eg_n = N_Req;
         end
         chk("p_gnt", P_Gnt, eg_p);
         chk("n_gnt", N_Gnt, eg_n);
         chk("busy", Busy, owner != 0);
         chk("dmem_en", DmemEn, eg_p | eg_n);

         exp_rv_p = 0; exp_rv_n = 0;
         if (eg_p || eg_n) begin
            wr = eg_p ? P_Wr    : N_Wr;
            ad = eg_p ? P_Addr  : N_Addr;
            wd = eg_p ? P_WData : N_WData;
            chk("dmem_wren", DmemWrEn, wr);
            chk("mem_addr", Mem_Addr, ad);
            if (wr) begin
               chk("data_out", Data_Out, wd);
               ref_mem[ad] = wd;
            end else if (eg_p) begin
               p_q.push_back(ref_mem[ad]); exp_rv_p = 1;
            end else begin
               n_q.push_back(ref_mem[ad]); exp_rv_n = 1;
            end
            last = eg_p ? 1 : 2;
         end

         // ownership
         if (owner != 0) begin
            held++;
            if (held >= LM) owner = 0;
            else if ((owner == 1 && eg_p && !P_Lock) || (owner == 2 && eg_n && !N_Lock)) owner = 0;
         end else if (eg_p && P_Lock) begin
            owner = 1; held = 0;
         end else if (eg_n && N_Lock) begin
            owner = 2; held = 0;
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic setp(input bit rq, input bit w, input bit lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
      P_Req = rq; P_Wr = w; P_Lock = lk; P_Addr = a; P_WData = d;
   endtask

   task automatic setn(input bit rq, input bit w, input bit lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
      N_Req = rq; N_Wr = w; N_Lock = lk; N_Addr = a; N_WData = d;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      case ($urandom_range(0, 3))
         0:       return 8'h10;
         1:       return 8'h20;
         2:       return 8'hFF;
         default: return AW'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) init_val[i] = {$urandom, $urandom};
      init_val[8'h10] = 64'hDEAD_BEEF_0000_0001;
      Reset = 1'b0;
      cyc(3);
      Reset = 1'b1;

      // processor read, NIC idle
      setp(1, 0, 0, 8'h10, '0); cyc();
      setp(0, 0, 0, 8'h00, '0); cyc(2);

      // both request every cycle
      setp(1, 0, 0, 8'h01, '0); setn(1, 0, 0, 8'h02, '0); cyc(8);
      setp(0, 0, 0, 8'h00, '0); setn(0, 0, 0, 8'h00, '0); cyc();

      // NIC locked read-modify-write with processor waiting
      setn(1, 0, 1, 8'h20, '0); cyc();
      setp(1, 0, 0, 8'h30, '0); setn(1, 1, 0, 8'h20, 64'h1234_5678_9ABC_DEF0); cyc();
      setn(0, 0, 0, 8'h00, '0); cyc();
      setp(1, 0, 0, 8'h20, '0); cyc();
      setp(0, 0, 0, 8'h00, '0); cyc();

      // processor holds lock well past the cap while NIC waits
      setn(1, 0, 0, 8'h05, '0);
      for (int i = 0; i < 20; i++) begin
         setp(1, 0, 1, AW'(i), '0); cyc();
      end
      setp(0, 0, 0, 8'h00, '0); setn(0, 0, 0, 8'h00, '0); cyc(2);

      // reset pulsed between a read grant and its return
      setp(1, 0, 0, 8'h10, '0); cyc();
      Reset = 1'b0; cyc(2);
      Reset = 1'b1;
      setp(1, 0, 0, 8'h11, '0); setn(1, 0, 0, 8'h12, '0); cyc();
      setp(0, 0, 0, 8'h00, '0); setn(0, 0, 0, 8'h00, '0); cyc(2);

      // write then immediate read of the top address
      setp(1, 1, 0, 8'hFF, 64'hFF); cyc();
      setp(1, 0, 0, 8'hFF, '0); cyc();
      setp(0, 0, 0, 8'h00, '0); cyc(2);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         setp($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              rnd_addr(), {$urandom, $urandom});
         setn($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              rnd_addr(), {$urandom, $urandom});
         cyc();
      end
      setp(0, 0, 0, 8'h00, '0); setn(0, 0, 0, 8'h00, '0);
      for (int i = 0; i < 20; i++) cyc();

      chk("p_q_drained", p_q.size(), 0);
      chk("n_q_drained", n_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter sharing the single-ported 256 x 64 data memory between the cardinal processor load/store path and a network-interface DMA engine. Sits between both masters and the dmem: it issues at most one access per cycle, returns read data to the issuing master with a valid strobe, and supports short locked sequences for atomic read-modify-write. Processor stalls are driven from its grant.

## Interface
- ADDR_W, 8, dmem word address width
- DATA_W, 64, dmem data width
- LOCK_MAX, 16, maximum consecutive cycles one master may hold a lock

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- P_Req / N_Req  in  1  processor / NIC access request
- P_Wr / N_Wr  in  1  1 = write, 0 = read
- P_Lock / N_Lock  in  1  keep ownership after the current access
- P_Addr / N_Addr  in  ADDR_W  word address
- P_WData / N_WData  in  DATA_W  write data
- P_Gnt / N_Gnt  out  1  access accepted this cycle
- P_RData / N_RData  out  DATA_W  read data
- P_RValid / N_RValid  out  1  read data valid
- DmemEn  out  1  dmem enable
- DmemWrEn  out  1  dmem write enable
- Mem_Addr  out  ADDR_W  dmem address
- Data_Out  out  DATA_W  dmem write data
- Data_In  in  DATA_W  dmem read data
- Busy  out  1  a lock is currently held

## Operation
- State machine: IDLE, OWN_P, OWN_N.
- IDLE: no request -> no grant, DmemEn=0. One request -> grant it. Both request -> winner per arbitration policy (see Configuration). Granted with Lock=1 -> move to OWN_x, lock counter cleared.
- OWN_x: only master x may be granted; the other master's Gnt stays 0 even if requesting. x granted with Lock=0 -> IDLE. Cycles without a grant still count toward the lock.
- Lock counter increments every cycle in OWN_x. Reaching LOCK_MAX-1 forces return to IDLE at the next edge, regardless of Lock.
- Grant cycle: DmemEn=1, DmemWrEn=Wr, Mem_Addr/Data_Out = the granted master's Addr/WData.
- Writes commit at the rising edge that ends the grant cycle.
- Reads: the dmem returns data one cycle after the grant. A registered tag routes Data_In to x_RData, and x_RValid=1 for exactly that cycle. The other master's RData is held; its RValid=0.
- Masters hold Req/Wr/Addr/WData stable until they see Gnt high.
- last_grant register records the last granted master. It updates on every grant.

## Timing
- Gnt is combinational from registered state plus Req. The dmem-side outputs are combinational from the selected master. Zero-cycle issue latency.
- Read latency: grant cycle N -> RValid/RData at cycle N+1. Back-to-back reads deliver one datum per cycle.
- Reset (async assert, sync release): state=IDLE, lock counter=0, last_grant=NIC (processor wins the first conflict), all Gnt/RValid/DmemEn/DmemWrEn/Busy=0, RData=0.
- Reset asserted between a read grant and its return: RValid is suppressed; no data is delivered.
- The lock owner releasing (Lock=0 on a granted access) in the same cycle the other master requests -> the other master is granted in the next cycle.
- Forced release at LOCK_MAX takes effect even while the owner is requesting. The owner then re-arbitrates in IDLE as a normal requester.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: on conflict in IDLE, grant the master not equal to last_grant.
- Not defined: fixed priority, processor always wins the conflict. last_grant is still maintained but unused for arbitration. Lock and LOCK_MAX behaviour are unchanged.

## Structure
- Shared package cardinal_pkg: ADDR_W/DATA_W constants, the master-ID enum (MST_P, MST_N) and the arbiter state enum.
- One sub-module, dmem_arb_pick: combinational two-way chooser taking requests, last_grant and the owner state, and producing the one-hot grant.
- The read-return tag register, lock counter and FSM live in the top module.

## Test plan
- Processor read of addr 0x10 (mem=0xDEAD_BEEF_0000_0001), NIC idle -> P_Gnt same cycle, P_RValid next cycle with that data, N_RValid=0.
- Both request every cycle with round-robin enabled -> grants alternate P,N,P,N. With the macro undefined -> P granted every cycle and N starved.
- NIC locked RMW: N reads 0x20 with Lock=1, then writes 0x20 with Lock=0 while P requests throughout -> P_Gnt=0 for both NIC cycles and granted on the third cycle. Mem[0x20] updated.
- P holds Lock=1 for 20 cycles with LOCK_MAX=16 -> forced to IDLE after 16 cycles, Busy drops, waiting N granted at the next conflict (round-robin).
- Read granted, Reset pulsed low the following cycle -> P_RValid stays 0, all outputs 0, first post-reset conflict grants P.
- Write 0xFF to addr 0xFF followed immediately by a read of 0xFF -> read returns 0xFF one cycle later (address wrap-free boundary).
